// File: rtl/complex_div_if.sv
// Operand/result handshake bundle for the complex divider.
// Master drives operands and out_ready; slave (the divider) drives results.
interface complex_div_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] num_real;
    logic signed [15:0] num_imag;
    logic signed [15:0] den_real;
    logic signed [15:0] den_imag;
    logic               out_valid;
    logic               out_ready;
    logic        [31:0] q_real;
    logic        [31:0] q_imag;
    logic               div_zero;

    modport master (
        output in_valid, num_real, num_imag, den_real, den_imag, out_ready,
        input  in_ready, out_valid, q_real, q_imag, div_zero
    );

    modport slave (
        input  in_valid, num_real, num_imag, den_real, den_imag, out_ready,
        output in_ready, out_valid, q_real, q_imag, div_zero
    );
endinterface

// File: rtl/complex_div.sv
// Complex divider (a+jb)/(c+jd): one multiply cycle, then two parallel 48-step
// restoring dividers producing saturated signed Q15.16 quotients.
module complex_div (
    input  logic          clk,
    input  logic          rst,
    complex_div_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_t;

    state_t             r_state;
    state_t             w_state_nx;

    logic signed [15:0] r_a, r_b, r_c, r_d;
    logic        [31:0] r_m;
    logic               r_neg_re, r_neg_im;
    logic        [47:0] r_div_re, r_div_im;
    logic        [31:0] r_rem_re, r_rem_im;
    logic        [5:0]  r_cnt;
    logic        [31:0] r_q_real, r_q_imag;
    logic               r_div_zero;

    logic signed [31:0] w_ac, w_bd, w_bc, w_ad, w_cc, w_dd;
    logic signed [32:0] w_p, w_q;
    logic        [31:0] w_m;
    logic        [31:0] w_mag_p, w_mag_q;

    logic        [32:0] w_sh_re, w_sh_im;
    logic               w_ge_re, w_ge_im;
    logic        [31:0] w_rem_nx_re, w_rem_nx_im;
    logic        [47:0] w_quo_nx_re, w_quo_nx_im;

    assign w_ac = 32'(r_a) * 32'(r_c);
    assign w_bd = 32'(r_b) * 32'(r_d);
    assign w_bc = 32'(r_b) * 32'(r_c);
    assign w_ad = 32'(r_a) * 32'(r_d);
    assign w_cc = 32'(r_c) * 32'(r_c);
    assign w_dd = 32'(r_d) * 32'(r_d);

    assign w_p = {w_ac[31], w_ac} + {w_bd[31], w_bd};
    assign w_q = {w_bc[31], w_bc} - {w_ad[31], w_ad};
    assign w_m = $unsigned(w_cc) + $unsigned(w_dd);

    // |P|,|Q| never exceed 2^31, so 32 bits hold the magnitude exactly.
    assign w_mag_p = w_p[32] ? 32'(-w_p) : w_p[31:0];
    assign w_mag_q = w_q[32] ? 32'(-w_q) : w_q[31:0];

    assign w_sh_re     = {r_rem_re, r_div_re[47]};
    assign w_sh_im     = {r_rem_im, r_div_im[47]};
    assign w_ge_re     = w_sh_re >= {1'b0, r_m};
    assign w_ge_im     = w_sh_im >= {1'b0, r_m};
    assign w_rem_nx_re = w_ge_re ? 32'(w_sh_re - {1'b0, r_m}) : w_sh_re[31:0];
    assign w_rem_nx_im = w_ge_im ? 32'(w_sh_im - {1'b0, r_m}) : w_sh_im[31:0];
    assign w_quo_nx_re = {r_div_re[46:0], w_ge_re};
    assign w_quo_nx_im = {r_div_im[46:0], w_ge_im};

    function automatic logic [31:0] f_sat(input logic [47:0] mag, input logic neg);
        logic [31:0] res;
        if (mag == '0) begin
            res = '0;
        end else if (!neg) begin
            res = (|mag[47:31]) ? 32'h7FFF_FFFF : {1'b0, mag[30:0]};
        end else if ((|mag[47:32]) || (mag[31] && (|mag[30:0]))) begin
            res = 32'h8000_0000;
        end else begin
            res = -mag[31:0];
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            StIdle:  if (bus.in_valid) w_state_nx = StMult;
            StMult:  w_state_nx = (w_m == '0) ? StDone : StDiv;
            StDiv:   if (r_cnt == 6'd47) w_state_nx = StDone;
            StDone:  if (bus.out_ready) w_state_nx = StIdle;
            default: w_state_nx = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_m        <= '0;
            r_neg_re   <= 1'b0;
            r_neg_im   <= 1'b0;
            r_div_re   <= '0;
            r_div_im   <= '0;
            r_rem_re   <= '0;
            r_rem_im   <= '0;
            r_cnt      <= '0;
            r_q_real   <= '0;
            r_q_imag   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_a <= bus.num_real;
                        r_b <= bus.num_imag;
                        r_c <= bus.den_real;
                        r_d <= bus.den_imag;
                    end
                end
                StMult: begin
                    r_m      <= w_m;
                    r_neg_re <= w_p[32];
                    r_neg_im <= w_q[32];
                    r_div_re <= {w_mag_p, 16'h0000};
                    r_div_im <= {w_mag_q, 16'h0000};
                    r_rem_re <= '0;
                    r_rem_im <= '0;
                    r_cnt    <= '0;
                    if (w_m == '0) begin
                        r_q_real   <= '0;
                        r_q_imag   <= '0;
                        r_div_zero <= 1'b1;
                    end
                end
                StDiv: begin
                    r_div_re <= w_quo_nx_re;
                    r_div_im <= w_quo_nx_im;
                    r_rem_re <= w_rem_nx_re;
                    r_rem_im <= w_rem_nx_im;
                    r_cnt    <= r_cnt + 6'd1;
                    // Last step: the final quotient bit is still combinational here.
                    if (r_cnt == 6'd47) begin
                        r_q_real   <= f_sat(w_quo_nx_re, r_neg_re);
                        r_q_imag   <= f_sat(w_quo_nx_im, r_neg_im);
                        r_div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.q_real    = r_q_real;
    assign bus.q_imag    = r_q_imag;
    assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_complex_div.sv
// Randomized self-checking bench for complex_div against an arithmetic reference model.
module tb_complex_div;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    complex_div_if bus ();

    complex_div u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint x);
        if (x > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (x < -64'sd2147483648) return 32'h8000_0000;
        else                           return 32'(x);
    endfunction

    task automatic model(input logic signed [15:0] a, b, c, d,
                         output logic [31:0] er, output logic [31:0] ei, output logic ez);
        longint p, q, m;
        p = longint'(a) * longint'(c) + longint'(b) * longint'(d);
        q = longint'(b) * longint'(c) - longint'(a) * longint'(d);
        m = longint'(c) * longint'(c) + longint'(d) * longint'(d);
        if (m == 0) begin
            er = '0;
            ei = '0;
            ez = 1'b1;
        end else begin
            er = sat32((p * 65536) / m);
            ei = sat32((q * 65536) / m);
            ez = 1'b0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic signed [15:0] a, b, c, d, input int bp);
        logic [31:0] er, ei;
        logic        ez;
        int          lat;
        int          exp_lat;
        model(a, b, c, d, er, ei, ez);
        exp_lat = ez ? 2 : 50;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.num_real  = a;
        bus.num_imag  = b;
        bus.den_real  = c;
        bus.den_imag  = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            // Scramble operand inputs while busy; the latched set must be used.
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.num_real = 16'($urandom);
            bus.num_imag = 16'($urandom);
            bus.den_real = 16'($urandom);
            bus.den_imag = 16'($urandom);
        end while (!bus.out_valid && lat < 200);
        check("latency", 64'(lat), 64'(exp_lat));
        check("q_real", 64'(bus.q_real), 64'(er));
        check("q_imag", 64'(bus.q_imag), 64'(ei));
        check("div_zero", 64'(bus.div_zero), 64'(ez));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            check("bp_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'd1);
            check("bp_data", {bus.q_real, bus.q_imag}, {er, ei});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_hs_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
        check("post_hs_data", {31'd0, bus.div_zero, bus.q_real, bus.q_imag},
              {31'd0, ez, er, ei});
    endtask

    initial begin
        logic signed [15:0] ext [5];
        logic signed [15:0] ra, rb, rc, rd;
        int                 mode;
        int                 ov_cnt;
        ext = '{16'sh8000, 16'sh7FFF, 16'sh0000, 16'sh0001, 16'shFFFF};
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.num_real  = '0;
        bus.num_imag  = '0;
        bus.den_real  = '0;
        bus.den_imag  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
        check("rst_data", {31'd0, bus.div_zero, bus.q_real, bus.q_imag}, 64'd0);

        run_op(16'sd1, 16'sd0, 16'sd1, 16'sd0, 0);
        run_op(16'sd0, 16'sd2, 16'sd1, 16'sd1, 0);
        run_op(16'sd1, 16'sd0, 16'sd0, 16'sd2, 1);
        run_op(-16'sd32768, 16'sd0, -16'sd1, 16'sd0, 0);
        run_op(16'sd5, 16'sd5, 16'sd0, 16'sd0, 10);
        run_op(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 2);
        run_op(16'sd7, -16'sd3, 16'sd2, 16'sd9, 3);

        // Abort mid-division; in_valid in the reset cycle must lose to rst.
        bus.num_real = 16'sd1000;
        bus.num_imag = 16'sd20;
        bus.den_real = 16'sd3;
        bus.den_imag = 16'sd4;
        bus.in_valid = 1'b1;
        repeat (22) begin
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("abort_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
        check("abort_data", {31'd0, bus.div_zero, bus.q_real, bus.q_imag}, 64'd0);
        ov_cnt = 0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) ov_cnt++;
        end
        check("abort_no_result", 64'(ov_cnt), 64'd0);
        run_op(16'sd1000, 16'sd20, 16'sd3, 16'sd4, 0);

        for (int n = 0; n < 30; n++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin
                    ra = 16'($urandom); rb = 16'($urandom);
                    rc = 16'($urandom); rd = 16'($urandom);
                end
                1: begin
                    ra = 16'(int'($urandom_range(0, 16)) - 8);
                    rb = 16'(int'($urandom_range(0, 16)) - 8);
                    rc = 16'(int'($urandom_range(0, 16)) - 8);
                    rd = 16'(int'($urandom_range(0, 16)) - 8);
                end
                2: begin
                    ra = 16'($urandom); rb = 16'($urandom);
                    rc = 16'sd0;        rd = 16'sd0;
                end
                default: begin
                    ra = ext[$urandom_range(0, 4)]; rb = ext[$urandom_range(0, 4)];
                    rc = ext[$urandom_range(0, 4)]; rd = ext[$urandom_range(0, 4)];
                end
            endcase
            run_op(ra, rb, rc, rd, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
